// File: rtl/slurm16_memory_responder.sv
// Memory-side responder for the slurm16 fetch and load/store ports.
// Arbitrates both onto one single-port SRAM with one-cycle read latency.
module slurm16_memory_responder #(
  parameter int ADDR_BITS  = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 instruction_request,
  input  logic [ADDR_BITS-1:0] instruction_address,
  output logic [15:0]          instruction_in,
  output logic [ADDR_BITS-1:0] instruction_address_in,
  output logic                 instruction_valid,
  input  logic                 load_memory,
  input  logic                 store_memory,
  input  logic [ADDR_BITS-1:0] load_store_address,
  input  logic [15:0]          memory_out,
  input  logic [1:0]           memory_mask,
  output logic [15:0]          memory_in,
  output logic                 memory_request_successful,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [15:0]          sram_wdata,
  output logic                 sram_wr,
  output logic [1:0]           sram_wmask,
  input  logic [15:0]          sram_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == STARVE_LIM) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0]     starve_cnt;
  logic                 data_req;
  logic                 starved;
  logic                 grant_fetch;
  logic                 grant_data;
  logic                 grant_store;
  logic                 grant_load;
  logic [ADDR_BITS-1:0] addr_hold;

  logic                 fetch_vld_p1;
  logic                 load_vld_p1;
  logic                 store_vld_p1;
  logic [ADDR_BITS-1:0] iaddr_p1;
  logic [15:0]          instr_hold;
  logic [15:0]          load_hold;

  // Stage p0: grant decision and SRAM command
  always_comb begin
    data_req    = (load_memory | store_memory) & ~memory_request_successful;
    starved     = (starve_cnt == STARVE_LIM);
    grant_fetch = ~RST & instruction_request & (~data_req | starved);
    grant_data  = ~RST & data_req & ~grant_fetch;
    grant_store = grant_data & store_memory;
    grant_load  = grant_data & ~store_memory;

    sram_addr = addr_hold;
    if (grant_fetch) begin
      sram_addr = instruction_address;
    end else if (grant_data) begin
      sram_addr = load_store_address;
    end
    sram_wr    = grant_store;
    sram_wdata = memory_out;
    sram_wmask = grant_store ? memory_mask : 2'b00;
  end

  // Stage p1: remember what was granted so the read data can be steered
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt   <= '0;
      addr_hold    <= '0;
      fetch_vld_p1 <= 1'b0;
      load_vld_p1  <= 1'b0;
      store_vld_p1 <= 1'b0;
      iaddr_p1     <= '0;
      instr_hold   <= '0;
      load_hold    <= '0;
    end else begin
      addr_hold    <= sram_addr;
      fetch_vld_p1 <= grant_fetch;
      load_vld_p1  <= grant_load;
      store_vld_p1 <= grant_store;
      if (grant_fetch) begin
        iaddr_p1 <= instruction_address;
      end
      if (fetch_vld_p1) begin
        instr_hold <= sram_rdata;
      end
      if (load_vld_p1) begin
        load_hold <= sram_rdata;
      end
      if (!instruction_request || grant_fetch) begin
        starve_cnt <= '0;
      end else if (grant_data) begin
        starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

  // Read data is forwarded in the response cycle; the hold registers cover idle cycles
  assign instruction_valid         = fetch_vld_p1 & ~RST;
  assign instruction_in            = RST ? '0 : (fetch_vld_p1 ? sram_rdata : instr_hold);
  assign instruction_address_in    = RST ? '0 : iaddr_p1;
  assign memory_request_successful = (load_vld_p1 | store_vld_p1) & ~RST;
  assign memory_in                 = RST ? '0 : (load_vld_p1 ? sram_rdata : load_hold);

endmodule

// File: tb/tb_slurm16_memory_responder.sv
// Directed bench for slurm16_memory_responder with an SRAM environment
// and a cycle-level reference model checked on every clock.
module tb_slurm16_memory_responder;
  localparam int AB = 15;
  localparam int SMAX = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ireq = 1'b0;
  logic [AB-1:0] iaddr = '0;
  logic [15:0]   instruction_in;
  logic [AB-1:0] instruction_address_in;
  logic          instruction_valid;
  logic          ld = 1'b0;
  logic          st = 1'b0;
  logic [AB-1:0] lsaddr = '0;
  logic [15:0]   mout = '0;
  logic [1:0]    mmask = 2'b11;
  logic [15:0]   memory_in;
  logic          memory_request_successful;
  logic [AB-1:0] sram_addr;
  logic [15:0]   sram_wdata;
  logic          sram_wr;
  logic [1:0]    sram_wmask;
  logic [15:0]   sram_rdata;

  int total = 0;
  int bad = 0;

  slurm16_memory_responder #(.ADDR_BITS(AB), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .instruction_request(ireq), .instruction_address(iaddr),
    .instruction_in(instruction_in), .instruction_address_in(instruction_address_in),
    .instruction_valid(instruction_valid),
    .load_memory(ld), .store_memory(st), .load_store_address(lsaddr),
    .memory_out(mout), .memory_mask(mmask), .memory_in(memory_in),
    .memory_request_successful(memory_request_successful),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wr(sram_wr),
    .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] init_val(input int i);
    if (i < 8) return 16'h3000 + 16'(i);
    if (i == 'h40) return 16'hBEEF;
    if (i == 'h10) return 16'h1234;
    return 16'(i) ^ 16'hA000;
  endfunction

  // SRAM environment
  logic [15:0] sram [0:(1<<AB)-1];
  always @(posedge CLK) begin
    if (sram_wr) begin
      if (sram_wmask[0]) sram[sram_addr][7:0] <= sram_wdata[7:0];
      if (sram_wmask[1]) sram[sram_addr][15:8] <= sram_wdata[15:8];
    end
    sram_rdata <= sram[sram_addr];
  end

  // Reference model: what the CPU must see, from the arbitration rules
  logic [15:0]   m_mem [0:(1<<AB)-1];
  logic          m_ready = 1'b0;
  logic          m_ivld, m_succ;
  logic [AB-1:0] m_iaddr;
  logic [15:0]   m_idata, m_mdata;
  int            m_lost;

  initial begin
    for (int i = 0; i < (1 << AB); i++) begin
      sram[i]  = init_val(i);
      m_mem[i] = init_val(i);
    end
  end

  function automatic bit fetch_wins();
    bit dreq;
    dreq = (ld || st) && !m_succ;
    return ireq && (!dreq || m_lost == SMAX);
  endfunction

  always @(posedge CLK) begin : model
    bit fw, dw;
    if (RST) begin
      m_ready <= 1'b1;
      m_ivld  <= 1'b0;
      m_succ  <= 1'b0;
      m_iaddr <= '0;
      m_idata <= '0;
      m_mdata <= '0;
      m_lost  <= 0;
    end else begin
      fw = fetch_wins();
      dw = (ld || st) && !m_succ && !fw;
      m_ivld <= fw;
      m_succ <= dw;
      if (fw) begin
        m_iaddr <= iaddr;
        m_idata <= m_mem[iaddr];
      end
      if (dw && !st) m_mdata <= m_mem[lsaddr];
      if (dw && st) begin
        if (mmask[0]) m_mem[lsaddr][7:0] <= mout[7:0];
        if (mmask[1]) m_mem[lsaddr][15:8] <= mout[15:8];
      end
      if (!ireq || fw) m_lost <= 0;
      else if (dw && m_lost < SMAX) m_lost <= m_lost + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process
  always @(negedge CLK) begin
    if (m_ready) begin
      chk("m_ivld", 32'(instruction_valid), RST ? 32'd0 : 32'(m_ivld));
      chk("m_succ", 32'(memory_request_successful), RST ? 32'd0 : 32'(m_succ));
      chk("m_iaddr", 32'(instruction_address_in), RST ? 32'd0 : 32'(m_iaddr));
      chk("m_idata", 32'(instruction_in), RST ? 32'd0 : 32'(m_idata));
      chk("m_mdata", 32'(memory_in), RST ? 32'd0 : 32'(m_mdata));
      chk("m_wr", 32'(sram_wr), 32'(!RST && st && !m_succ && !fetch_wins()));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(input bit is_st, input logic [AB-1:0] a, input logic [15:0] d,
                       input logic [1:0] m);
    bit seen;
    tick();
    ld = !is_st; st = is_st; lsaddr = a; mout = d; mmask = m;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge CLK);
      if (memory_request_successful) begin
        seen = 1;
        break;
      end
    end
    chk("op_done", 32'(seen), 32'd1);
    tick();
    ld = 0; st = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int run, maxrun, nf, nd, nwr, nvl;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk("rst_ivld", 32'(instruction_valid), 32'd0);
    chk("rst_succ", 32'(memory_request_successful), 32'd0);
    chk("rst_mdata", 32'(memory_in), 32'd0);

    // T1 fetch stream
    for (int i = 0; i <= 8; i++) begin
      tick();
      ireq = (i < 8);
      iaddr = AB'(i);
      @(negedge CLK);
      if (i > 0) begin
        chk("t1_vld", 32'(instruction_valid), 32'd1);
        chk("t1_data", 32'(instruction_in), 32'h3000 + 32'(i - 1));
        chk("t1_addr", 32'(instruction_address_in), 32'(i - 1));
      end
    end
    tick(); ireq = 0;

    // T2 load contention
    tick(); ireq = 1; iaddr = 'h100;
    tick(); iaddr = 'h101; ld = 1; lsaddr = 'h40;
    @(negedge CLK);
    chk("t2_pre_vld", 32'(instruction_valid), 32'd1);
    tick();
    @(negedge CLK);
    chk("t2_bubble", 32'(instruction_valid), 32'd0);
    chk("t2_succ", 32'(memory_request_successful), 32'd1);
    chk("t2_data", 32'(memory_in), 32'hBEEF);
    tick(); ld = 0; iaddr = 'h102;
    @(negedge CLK);
    chk("t2_resume", 32'(instruction_valid), 32'd1);
    chk("t2_raddr", 32'(instruction_address_in), 32'h101);
    chk("t2_pulse1", 32'(memory_request_successful), 32'd0);
    chk("t2_hold", 32'(memory_in), 32'hBEEF);
    tick(); ireq = 0;

    // T3 store low byte
    tick(); st = 1; lsaddr = 'h10; mout = 16'hA5C3; mmask = 2'b01;
    @(negedge CLK);
    chk("t3_wr", 32'(sram_wr), 32'd1);
    chk("t3_mask", 32'(sram_wmask), 32'd1);
    chk("t3_addr", 32'(sram_addr), 32'h10);
    tick();
    @(negedge CLK);
    chk("t3_succ", 32'(memory_request_successful), 32'd1);
    chk("t3_wr_once", 32'(sram_wr), 32'd0);
    chk("t3_min", 32'(memory_in), 32'hBEEF);
    tick(); st = 0; mmask = 2'b11;
    @(negedge CLK);
    chk("t3_word", 32'(sram['h10]), 32'h12C3);

    // Other lanes, empty mask, then read back
    do_op(1, 'h12, 16'h7788, 2'b10);
    do_op(1, 'h11, 16'hFFFF, 2'b00);
    do_op(1, 'h13, 16'hCAFE, 2'b11);
    do_op(0, 'h12, 16'h0, 2'b11);
    chk("hi_lane", 32'(memory_in), 32'h7712);
    do_op(0, 'h11, 16'h0, 2'b11);
    chk("mask00", 32'(memory_in), 32'hA011);
    do_op(0, 'h13, 16'h0, 2'b11);
    chk("word", 32'(memory_in), 32'hCAFE);
    do_op(0, 'h10, 16'h0, 2'b11);
    chk("lo_lane", 32'(memory_in), 32'h12C3);

    // T4 starvation: loads always pending alongside fetches
    run = 0; maxrun = 0; nf = 0; nd = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      ireq = 1; iaddr = AB'('h200 + c); ld = 1; lsaddr = AB'('h40 + nd);
      @(negedge CLK);
      if (c > 0) begin
        if (instruction_valid) begin
          nf++; run = 0;
        end else begin
          run++;
          if (run > maxrun) maxrun = run;
        end
      end
      if (memory_request_successful) nd++;
    end
    chk("t4_run", 32'(maxrun <= SMAX), 32'd1);
    chk("t4_fetches", 32'(nf >= 6), 32'd1);
    chk("t4_loads", 32'(nd >= 6), 32'd1);
    tick(); ireq = 0; ld = 0;
    tick();

    // T5 reset in the cycle after a load grant
    tick(); ld = 1; lsaddr = 'h41;
    tick(); RST = 1;
    @(negedge CLK);
    chk("t5_succ", 32'(memory_request_successful), 32'd0);
    chk("t5_vld", 32'(instruction_valid), 32'd0);
    chk("t5_min", 32'(memory_in), 32'd0);
    chk("t5_iin", 32'(instruction_in), 32'd0);
    chk("t5_iai", 32'(instruction_address_in), 32'd0);
    tick(); RST = 0;
    @(negedge CLK);
    chk("t5_nopulse", 32'(memory_request_successful), 32'd0);
    tick();
    @(negedge CLK);
    chk("t5_retry", 32'(memory_request_successful), 32'd1);
    chk("t5_data", 32'(memory_in), 32'hA041);
    tick(); ld = 0;
    tick();

    // T6 idle
    nwr = 0; nvl = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge CLK);
      if (sram_wr) nwr++;
      if (instruction_valid || memory_request_successful) nvl++;
    end
    chk("t6_wr", 32'(nwr), 32'd0);
    chk("t6_vld", 32'(nvl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
